// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: response encodings and the response type.
// Used by both the read and write slaves.
package axi4_lite_pkg;

  typedef logic [1:0] axil_resp_t;

  localparam axil_resp_t RESP_OKAY   = 2'b00;
  localparam axil_resp_t RESP_EXOKAY = 2'b01;
  localparam axil_resp_t RESP_SLVERR = 2'b10;
  localparam axil_resp_t RESP_DECERR = 2'b11;

endpackage

// File: rtl/axil_resp_fifo.sv
// Synchronous response FIFO. Head entry is presented combinationally on dout.
// Pointers carry one extra MSB so full and empty can be told apart when the
// index bits match.
module axil_resp_fifo #(
  parameter int WIDTH = 34,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                   (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr[PTR_W-1:0]];

  // Pointer update; both pointers wrap naturally through the extra MSB.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PTR_W-1:0]] <= din;
  end

endmodule

// File: rtl/axi4_lite_read_slave_pipe.sv
// Pipelined AXI4-Lite read slave in front of a fixed-latency backend.
// Optional feature macro: AXIL_RD_ALIGN_CHECK_EN (misaligned in-range reads
// answer SLVERR without touching the backend).
//
// Handshake rule for both channels: a transfer happens on the rising edge
// where VALID and READY are both 1; the source holds VALID and its payload
// stable until that edge, and READY never depends combinationally on VALID.
//
// Data path per read: AR handshake -> issue stage (rd_en, tag stage 0) ->
// RD_LATENCY tag stages (last one lines up with rd_data) -> capture register
// -> response FIFO -> R channel. The credit counter spans the whole path, so
// the FIFO can never receive more entries than it holds.
module axi4_lite_read_slave_pipe
  import axi4_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH      = 32,
  parameter int                    DATA_WIDTH      = 32,
  parameter int                    RD_LATENCY      = 1,
  parameter int                    MAX_OUTSTANDING = 4,
  parameter logic [ADDR_WIDTH-1:0] ADDR_BASE       = '0,
  parameter logic [ADDR_WIDTH:0]   ADDR_SIZE       = 'h1000
) (
  input  logic                  clk,
  input  logic                  resetn,
  output logic                  rd_en,
  output logic [ADDR_WIDTH-1:0] rd_addr,
  input  logic [DATA_WIDTH-1:0] rd_data,
  input  logic [ADDR_WIDTH-1:0] AR_ADDR,
  input  logic                  AR_VALID,
  output logic                  AR_READY,
  output logic [DATA_WIDTH-1:0] R_DATA,
  output logic [1:0]            R_RESP,
  output logic                  R_VALID,
  input  logic                  R_READY
);

  localparam int CNT_W  = $clog2(MAX_OUTSTANDING + 1);
  localparam int FIFO_W = DATA_WIDTH + 2;

  logic                  ar_hs;
  logic                  r_hs;
  logic [CNT_W-1:0]      credit_cnt;
  logic [CNT_W-1:0]      credit_nxt;
  logic                  in_range;
  logic                  misaligned;
  axil_resp_t            ar_resp;
  logic                  issue;

  logic [RD_LATENCY:0]   pipe_v;
  axil_resp_t            pipe_resp [RD_LATENCY+1];

  logic                  cap_v;
  axil_resp_t            cap_resp;
  logic [DATA_WIDTH-1:0] cap_data;

  logic [FIFO_W-1:0]     fifo_dout;
  logic                  fifo_full;
  logic                  fifo_empty;

  assign ar_hs = AR_VALID && AR_READY;
  assign r_hs  = R_VALID && R_READY;

  // Credit bookkeeping: one credit per read from AR acceptance to R completion.
  always_comb begin
    credit_nxt = credit_cnt;
    case ({ar_hs, r_hs})
      2'b10:   credit_nxt = credit_cnt + CNT_W'(1);
      2'b01:   credit_nxt = credit_cnt - CNT_W'(1);
      default: credit_nxt = credit_cnt;
    endcase
  end

  // Address decode: range check first, then the optional alignment check.
  always_comb begin
    in_range = ({1'b0, AR_ADDR} >= {1'b0, ADDR_BASE}) &&
               ({1'b0, AR_ADDR} <  ({1'b0, ADDR_BASE} + ADDR_SIZE));
`ifdef AXIL_RD_ALIGN_CHECK_EN
    misaligned = |AR_ADDR[$clog2(DATA_WIDTH/8)-1:0];
`else
    misaligned = 1'b0;
`endif
    if (!in_range)       ar_resp = RESP_DECERR;
    else if (misaligned) ar_resp = RESP_SLVERR;
    else                 ar_resp = RESP_OKAY;
    issue = ar_hs && (ar_resp == RESP_OKAY);
  end

  // Credit counter and registered AR_READY derived from next-cycle credits.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      credit_cnt <= '0;
      AR_READY   <= 1'b0;
    end else begin
      credit_cnt <= credit_nxt;
      AR_READY   <= (credit_nxt < CNT_W'(MAX_OUTSTANDING));
    end
  end

  // Backend issue: strobe only for good reads; rd_addr holds otherwise.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_en   <= 1'b0;
      rd_addr <= '0;
    end else begin
      rd_en <= issue;
      if (issue) rd_addr <= AR_ADDR;
    end
  end

  // Tag pipeline: every accepted read, error or not, travels in order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pipe_v <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) pipe_resp[i] <= RESP_OKAY;
    end else begin
      pipe_v[0]    <= ar_hs;
      pipe_resp[0] <= ar_resp;
      for (int i = 1; i <= RD_LATENCY; i++) begin
        pipe_v[i]    <= pipe_v[i-1];
        pipe_resp[i] <= pipe_resp[i-1];
      end
    end
  end

  // Capture backend data alongside its tag; error responses carry zero data.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cap_v    <= 1'b0;
      cap_resp <= RESP_OKAY;
      cap_data <= '0;
    end else begin
      cap_v    <= pipe_v[RD_LATENCY];
      cap_resp <= pipe_resp[RD_LATENCY];
      cap_data <= (pipe_resp[RD_LATENCY] == RESP_OKAY) ? rd_data : '0;
    end
  end

  axil_resp_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (MAX_OUTSTANDING)
  ) u_resp_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (cap_v),
    .pop    (r_hs),
    .din    ({cap_resp, cap_data}),
    .dout   (fifo_dout),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  assign R_VALID = !fifo_empty;
  assign R_DATA  = R_VALID ? fifo_dout[DATA_WIDTH-1:0] : '0;
  assign R_RESP  = R_VALID ? fifo_dout[DATA_WIDTH +: 2] : RESP_OKAY;

  // The credit limit must keep the FIFO from ever being pushed while full.
  a_no_overflow: assert property (@(posedge clk) disable iff (!resetn)
    !(cap_v && fifo_full && !r_hs));

  // Credits never exceed the FIFO depth.
  a_credit_bound: assert property (@(posedge clk) disable iff (!resetn)
    credit_cnt <= CNT_W'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_axi4_lite_read_slave_pipe.sv
// Directed bench for axi4_lite_read_slave_pipe (default parameters,
// RD_LATENCY=1, MAX_OUTSTANDING=4). Inputs change 1 time unit after the
// rising edge; outputs are sampled on the falling edge.
module tb_axi4_lite_read_slave_pipe;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        rd_en;
  logic [31:0] rd_addr;
  logic [31:0] rd_data = 32'h0;
  logic [31:0] AR_ADDR = 32'h0;
  logic        AR_VALID = 1'b0;
  logic        AR_READY;
  logic [31:0] R_DATA;
  logic [1:0]  R_RESP;
  logic        R_VALID;
  logic        R_READY = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  logic [33:0] exp_q[$];
  logic [33:0] got_q[$];
  int          got_cyc[$];
  logic [31:0] iss_q[$];

  axi4_lite_read_slave_pipe dut (
    .clk      (clk),
    .resetn   (resetn),
    .rd_en    (rd_en),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .AR_ADDR  (AR_ADDR),
    .AR_VALID (AR_VALID),
    .AR_READY (AR_READY),
    .R_DATA   (R_DATA),
    .R_RESP   (R_RESP),
    .R_VALID  (R_VALID),
    .R_READY  (R_READY)
  );

  // Clock
  always #5 clk = ~clk;

  // Watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [31:0] bk_val(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return 32'hC0DE0000 | {16'h0, a[15:0]};
  endfunction

  // Backend model: data appears one cycle after the rd_en cycle.
  initial begin : backend
    logic        en;
    logic [31:0] a;
    forever begin
      @(negedge clk);
      en = rd_en;
      a  = rd_addr;
      @(posedge clk);
      #1;
      if (en) rd_data = bk_val(a);
    end
  end

  // Monitor: log R beats about to complete and backend strobes.
  initial begin : monitor
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn) begin
        if (R_VALID && R_READY) begin
          got_q.push_back({R_RESP, R_DATA});
          got_cyc.push_back(cyc);
        end
        if (rd_en) iss_q.push_back(rd_addr);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one AR request and wait (bounded) for its handshake.
  task automatic ar_send(input logic [31:0] a, output int hs_cyc);
    logic hs;
    logic done;
    done = 1'b0;
    hs_cyc = -1;
    AR_ADDR  = a;
    AR_VALID = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      hs = AR_READY;
      @(posedge clk);
      #1;
      if (hs) begin
        done = 1'b1;
        hs_cyc = cyc;
      end
    end
    if (!done) chk("ar_handshake_timeout", 64'd0, 64'd1);
  endtask

  task automatic ar_idle();
    AR_VALID = 1'b0;
  endtask

  task automatic expect_beat(input logic [1:0] resp, input logic [31:0] data);
    exp_q.push_back({resp, data});
  endtask

  // Wait for all expected beats, then compare them in order.
  task automatic drain(input string tag);
    int n;
    for (int i = 0; i < 100 && got_q.size() < exp_q.size(); i++) @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk({tag, "_count"}, 64'(got_q.size()), 64'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk($sformatf("%s_beat%0d", tag, i), 64'(got_q[i]), 64'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin : stimulus
    int c0, c1, c2, c3, c4;

    // 1: reset state and AR_READY rise
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rd_en", 64'(rd_en), 64'd0);
    chk("rst_rd_addr", 64'(rd_addr), 64'd0);
    chk("rst_ar_ready", 64'(AR_READY), 64'd0);
    chk("rst_r_valid", 64'(R_VALID), 64'd0);
    chk("rst_r_data", 64'(R_DATA), 64'd0);
    chk("rst_r_resp", 64'(R_RESP), 64'd0);
    @(posedge clk);
    #1 resetn = 1'b1;
    @(negedge clk);
    chk("ar_ready_before_edge", 64'(AR_READY), 64'd0);
    @(negedge clk);
    chk("ar_ready_after_edge", 64'(AR_READY), 64'd1);
    chk("r_valid_after_rst", 64'(R_VALID), 64'd0);
    @(posedge clk);
    #1;

    // 2: single read, latency and data
    ar_send(32'h10, c0);
    ar_idle();
    @(negedge clk);
    chk("t2_rd_en", 64'(rd_en), 64'd1);
    chk("t2_rd_addr", 64'(rd_addr), 64'h10);
    @(negedge clk);
    chk("t2_rd_en_pulse", 64'(rd_en), 64'd0);
    chk("t2_r_valid_c2", 64'(R_VALID), 64'd0);
    @(negedge clk);
    chk("t2_r_valid_c3m", 64'(R_VALID), 64'd0);
    @(negedge clk);
    chk("t2_r_valid", 64'(R_VALID), 64'd1);
    chk("t2_r_data", 64'(R_DATA), 64'hDEADBEEF);
    chk("t2_r_resp", 64'(R_RESP), 64'd0);
    @(posedge clk);
    #1 R_READY = 1'b1;
    expect_beat(2'b00, 32'hDEADBEEF);
    drain("t2");
    got_cyc.delete();

    // 3: four back-to-back reads with R_READY=1
    @(posedge clk);
    #1;
    ar_send(32'h0, c1);
    ar_send(32'h4, c2);
    ar_send(32'h8, c3);
    ar_send(32'hC, c4);
    ar_idle();
    chk("t3_no_ar_stall", 64'(c4 - c1), 64'd3);
    expect_beat(2'b00, 32'hC0DE0000);
    expect_beat(2'b00, 32'hC0DE0004);
    expect_beat(2'b00, 32'hC0DE0008);
    expect_beat(2'b00, 32'hC0DE000C);
    drain("t3");
    if (got_cyc.size() == 4) chk("t3_back_to_back", 64'(got_cyc[3] - got_cyc[0]), 64'd3);
    else chk("t3_beat_cycles", 64'(got_cyc.size()), 64'd4);
    got_cyc.delete();

    // 4: backpressure, credit limit, stable R payload
    @(posedge clk);
    #1 R_READY = 1'b0;
    ar_send(32'h20, c1);
    ar_send(32'h24, c2);
    ar_send(32'h28, c3);
    ar_send(32'h2C, c4);
    AR_ADDR  = 32'h30;
    AR_VALID = 1'b1;
    @(negedge clk);
    chk("t4_ar_ready_full", 64'(AR_READY), 64'd0);
    chk("t4_r_valid", 64'(R_VALID), 64'd1);
    chk("t4_r_data", 64'(R_DATA), 64'hC0DE0020);
    repeat (3) @(negedge clk);
    chk("t4_ar_ready_held", 64'(AR_READY), 64'd0);
    chk("t4_r_valid_held", 64'(R_VALID), 64'd1);
    chk("t4_r_data_stable", 64'(R_DATA), 64'hC0DE0020);
    chk("t4_r_resp_stable", 64'(R_RESP), 64'd0);
    @(posedge clk);
    #1 R_READY = 1'b1;
    ar_send(32'h30, c0);
    ar_idle();
    expect_beat(2'b00, 32'hC0DE0020);
    expect_beat(2'b00, 32'hC0DE0024);
    expect_beat(2'b00, 32'hC0DE0028);
    expect_beat(2'b00, 32'hC0DE002C);
    expect_beat(2'b00, 32'hC0DE0030);
    drain("t4");
    got_cyc.delete();

    // 5: out-of-range read between two good reads
    iss_q.delete();
    @(posedge clk);
    #1;
    ar_send(32'h40, c1);
    ar_send(32'h2000, c2);
    ar_send(32'h44, c3);
    ar_idle();
    expect_beat(2'b00, 32'hC0DE0040);
    expect_beat(2'b11, 32'h0);
    expect_beat(2'b00, 32'hC0DE0044);
    drain("t5");
    chk("t5_issue_count", 64'(iss_q.size()), 64'd2);
    if (iss_q.size() == 2) begin
      chk("t5_issue0", 64'(iss_q[0]), 64'h40);
      chk("t5_issue1", 64'(iss_q[1]), 64'h44);
    end
    got_cyc.delete();

    // 6a: misaligned in-range read
    iss_q.delete();
    @(posedge clk);
    #1;
    ar_send(32'h6, c1);
    ar_idle();
`ifdef AXIL_RD_ALIGN_CHECK_EN
    expect_beat(2'b10, 32'h0);
    drain("t6_align");
    chk("t6_issue_count", 64'(iss_q.size()), 64'd0);
`else
    expect_beat(2'b00, 32'hC0DE0006);
    drain("t6_align");
    chk("t6_issue_count", 64'(iss_q.size()), 64'd1);
`endif
    got_cyc.delete();

    // 6b: reset with three reads in flight
    @(posedge clk);
    #1 R_READY = 1'b0;
    ar_send(32'h50, c1);
    ar_send(32'h54, c2);
    ar_send(32'h58, c3);
    ar_idle();
    @(posedge clk);
    #1 resetn = 1'b0;
    @(negedge clk);
    chk("t6_rst_r_valid", 64'(R_VALID), 64'd0);
    chk("t6_rst_ar_ready", 64'(AR_READY), 64'd0);
    chk("t6_rst_rd_en", 64'(rd_en), 64'd0);
    got_q.delete();
    exp_q.delete();
    got_cyc.delete();
    repeat (2) @(posedge clk);
    #1;
    resetn  = 1'b1;
    R_READY = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("t6_no_stale_beat", 64'(got_q.size()), 64'd0);
    ar_send(32'h60, c1);
    ar_idle();
    expect_beat(2'b00, 32'hC0DE0060);
    drain("t6_post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
